id_stage: RTL and testbench

- Decode stage that sits directly upstream of the execute ALU.
- Accepts a fetched 32-bit instruction plus its PC from fetch over a valid/ready handshake.
- Splits the instruction into opcode, funct3, funct7, 12-bit immediate and register indices, then reads the register file with write-back bypass.
- Presents a registered, skid-buffered bundle to execute over a second valid/ready handshake.

---
 rtl/id_stage_pkg.sv | 33 +++
 rtl/id_decode.sv | 52 +++++
 rtl/id_stage.sv | 116 +++++++++++
 tb/tb_id_stage.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/id_stage_pkg.sv
// Shared types for the decode stage: opcode constants, the decode-to-execute
// bundle, and the occupancy encoding of the output/skid pair.
package id_stage_pkg;

    localparam int ID_XLEN = 64;

    localparam logic [6:0] OP_REG = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;

    typedef struct packed {
        logic [ID_XLEN-1:0] pc;
        logic [6:0]         opcode;
        logic [2:0]         funct3;
        logic [6:0]         funct7;
        logic [11:0]        immed;
        logic [ID_XLEN-1:0] reg1;
        logic [ID_XLEN-1:0] reg2;
        logic [4:0]         rd;
        logic               wen;
        logic               illegal;
    } id_ex_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } occ_t;

    function automatic logic is_alu_op(input logic [6:0] opcode);
        return (opcode == OP_REG) || (opcode == OP_IMM);
    endfunction

endpackage

// File: rtl/id_decode.sv
// Combinational field split, write-back bypass and x0 forcing for one instruction.
module id_decode
    import id_stage_pkg::*;
#(
    parameter int XLEN = ID_XLEN,
    parameter int ILEN = 32
) (
    input  logic [ILEN-1:0] instr,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rf_rdata1,
    input  logic [XLEN-1:0] rf_rdata2,
    input  logic            wb_wen,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output id_ex_t          bundle
);

    function automatic logic [XLEN-1:0] operand(
        input logic [4:0]      idx,
        input logic [XLEN-1:0] rdata,
        input logic            bwen,
        input logic [4:0]      brd,
        input logic [XLEN-1:0] bdata
    );
        if (idx == 5'd0)
            return '0;
        else if (bwen && (brd == idx))
            return bdata;
        else
            return rdata;
    endfunction

    assign rs1 = instr[19:15];
    assign rs2 = instr[24:20];

    always_comb begin
        bundle         = '0;
        bundle.pc      = pc;
        bundle.opcode  = instr[6:0];
        bundle.funct3  = instr[14:12];
        bundle.funct7  = instr[31:25];
        bundle.immed   = instr[31:20];
        bundle.rd      = instr[11:7];
        bundle.reg1    = operand(rs1, rf_rdata1, wb_wen, wb_rd, wb_data);
        bundle.reg2    = operand(rs2, rf_rdata2, wb_wen, wb_rd, wb_data);
        bundle.illegal = !is_alu_op(instr[6:0]);
        bundle.wen     = is_alu_op(instr[6:0]) && (instr[11:7] != 5'd0);
    end

endmodule

// File: rtl/id_stage.sv
// Decode stage: accepts from fetch, decodes, and holds the result in an
// output register backed by one skid entry so if_ready never waits on ex_ready.
module id_stage
    import id_stage_pkg::*;
#(
    parameter int XLEN = ID_XLEN,
    parameter int ILEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            if_valid,
    output logic            if_ready,
    input  logic [XLEN-1:0] if_pc,
    input  logic [ILEN-1:0] if_instr,
    output logic [4:0]      rf_raddr1,
    output logic [4:0]      rf_raddr2,
    input  logic [XLEN-1:0] rf_rdata1,
    input  logic [XLEN-1:0] rf_rdata2,
    input  logic            wb_wen,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [XLEN-1:0] ex_pc,
    output logic [6:0]      ex_opcode,
    output logic [2:0]      ex_funct3,
    output logic [6:0]      ex_funct7,
    output logic [11:0]     ex_immed,
    output logic [XLEN-1:0] ex_reg1,
    output logic [XLEN-1:0] ex_reg2,
    output logic [4:0]      ex_rd,
    output logic            ex_wen,
    output logic            ex_illegal
);

    id_ex_t dec_p0;
    id_ex_t out_p1;
    id_ex_t skid_p1;
    occ_t   state;
    logic   rdy_en;
    logic   accept;
    logic   drain;

    id_decode #(.XLEN(XLEN), .ILEN(ILEN)) u_decode (
        .instr     (if_instr),
        .pc        (if_pc),
        .rf_rdata1 (rf_rdata1),
        .rf_rdata2 (rf_rdata2),
        .wb_wen    (wb_wen),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .rs1       (rf_raddr1),
        .rs2       (rf_raddr2),
        .bundle    (dec_p0)
    );

    // rdy_en holds if_ready low until the first edge after reset releases.
    assign if_ready = rdy_en && (state != ST_FULL);
    assign ex_valid = (state != ST_EMPTY);
    assign accept   = if_valid && if_ready;
    assign drain    = ex_valid && ex_ready;

    // ---- p0 -> p1: decoded bundle enters OUT or SKID ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_EMPTY;
            rdy_en  <= 1'b0;
            out_p1  <= '0;
            skid_p1 <= '0;
        end else begin
            rdy_en <= 1'b1;
            if (flush) begin
                state <= ST_EMPTY;
            end else begin
                unique case (state)
                    ST_EMPTY: begin
                        if (accept) begin
                            out_p1 <= dec_p0;
                            state  <= ST_ONE;
                        end
                    end
                    ST_ONE: begin
                        if (accept && drain) begin
                            out_p1 <= dec_p0;
                        end else if (drain) begin
                            state <= ST_EMPTY;
                        end else if (accept) begin
                            skid_p1 <= dec_p0;
                            state   <= ST_FULL;
                        end
                    end
                    ST_FULL: begin
                        if (drain) begin
                            out_p1 <= skid_p1;
                            state  <= ST_ONE;
                        end
                    end
                    default: state <= ST_EMPTY;
                endcase
            end
        end
    end

    assign ex_pc      = out_p1.pc;
    assign ex_opcode  = out_p1.opcode;
    assign ex_funct3  = out_p1.funct3;
    assign ex_funct7  = out_p1.funct7;
    assign ex_immed   = out_p1.immed;
    assign ex_reg1    = out_p1.reg1;
    assign ex_reg2    = out_p1.reg2;
    assign ex_rd      = out_p1.rd;
    assign ex_wen     = out_p1.wen;
    assign ex_illegal = out_p1.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: decode fields, bypass, backpressure, flush, reset.
module tb_id_stage;

    localparam int XLEN = 64;
    localparam int ILEN = 32;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            flush = 1'b0;
    logic            if_valid = 1'b0;
    logic            if_ready;
    logic [XLEN-1:0] if_pc = '0;
    logic [ILEN-1:0] if_instr = '0;
    logic [4:0]      rf_raddr1;
    logic [4:0]      rf_raddr2;
    logic [XLEN-1:0] rf_rdata1 = '0;
    logic [XLEN-1:0] rf_rdata2 = '0;
    logic            wb_wen = 1'b0;
    logic [4:0]      wb_rd = '0;
    logic [XLEN-1:0] wb_data = '0;
    logic            ex_valid;
    logic            ex_ready = 1'b0;
    logic [XLEN-1:0] ex_pc;
    logic [6:0]      ex_opcode;
    logic [2:0]      ex_funct3;
    logic [6:0]      ex_funct7;
    logic [11:0]     ex_immed;
    logic [XLEN-1:0] ex_reg1;
    logic [XLEN-1:0] ex_reg2;
    logic [4:0]      ex_rd;
    logic            ex_wen;
    logic            ex_illegal;

    int vectors = 0;
    int miscompares = 0;

    id_stage #(.XLEN(XLEN), .ILEN(ILEN)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .if_valid   (if_valid),
        .if_ready   (if_ready),
        .if_pc      (if_pc),
        .if_instr   (if_instr),
        .rf_raddr1  (rf_raddr1),
        .rf_raddr2  (rf_raddr2),
        .rf_rdata1  (rf_rdata1),
        .rf_rdata2  (rf_rdata2),
        .wb_wen     (wb_wen),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .ex_valid   (ex_valid),
        .ex_ready   (ex_ready),
        .ex_pc      (ex_pc),
        .ex_opcode  (ex_opcode),
        .ex_funct3  (ex_funct3),
        .ex_funct7  (ex_funct7),
        .ex_immed   (ex_immed),
        .ex_reg1    (ex_reg1),
        .ex_reg2    (ex_reg2),
        .ex_rd      (ex_rd),
        .ex_wen     (ex_wen),
        .ex_illegal (ex_illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [63:0] pc, input logic [31:0] instr,
                         input logic [63:0] d1, input logic [63:0] d2);
        if_valid  = 1'b1;
        if_pc     = pc;
        if_instr  = instr;
        rf_rdata1 = d1;
        rf_rdata2 = d2;
    endtask

    initial begin
        // Reset state
        #1 reset = 1'b1;
        #1;
        chk("rst_ex_valid", ex_valid, 0);
        chk("rst_ex_pc", ex_pc, 0);
        chk("rst_ex_reg1", ex_reg1, 0);
        chk("rst_ex_opcode", ex_opcode, 0);
        chk("rst_if_ready", if_ready, 0);
        tick();
        tick();
        reset = 1'b0;
        chk("post_rst_if_ready_low", if_ready, 0);
        tick();
        chk("post_rst_if_ready_high", if_ready, 1);

        // ADD x3,x1,x2
        ex_ready = 1'b1;
        offer(64'h8000_0000, 32'h002081B3, 64'd5, 64'd7);
        #1;
        chk("add_raddr1", rf_raddr1, 1);
        chk("add_raddr2", rf_raddr2, 2);
        tick();
        chk("add_valid", ex_valid, 1);
        chk("add_pc", ex_pc, 64'h8000_0000);
        chk("add_opcode", ex_opcode, 7'h33);
        chk("add_funct3", ex_funct3, 0);
        chk("add_funct7", ex_funct7, 0);
        chk("add_rd", ex_rd, 3);
        chk("add_reg1", ex_reg1, 5);
        chk("add_reg2", ex_reg2, 7);
        chk("add_wen", ex_wen, 1);
        chk("add_illegal", ex_illegal, 0);

        // ADDI x5,x0,-1: x0 reads zero even with a matching-looking bypass to x0
        offer(64'h8000_0004, 32'hFFF00293, 64'hDEAD, 64'h0);
        wb_wen = 1'b1; wb_rd = 5'd0; wb_data = 64'h55;
        tick();
        wb_wen = 1'b0;
        chk("addi_valid", ex_valid, 1);
        chk("addi_pc", ex_pc, 64'h8000_0004);
        chk("addi_opcode", ex_opcode, 7'h13);
        chk("addi_reg1", ex_reg1, 0);
        chk("addi_immed", ex_immed, 12'hFFF);
        chk("addi_rd", ex_rd, 5);
        chk("addi_wen", ex_wen, 1);

        // ADDI x0,x1,1 writes x0 -> no write enable
        offer(64'h8000_0008, 32'h00108013, 64'd4, 64'd0);
        tick();
        chk("addi_x0_rd", ex_rd, 0);
        chk("addi_x0_immed", ex_immed, 1);
        chk("addi_x0_reg1", ex_reg1, 4);
        chk("addi_x0_wen", ex_wen, 0);

        // Bypass from write-back to rs1
        offer(64'h8000_000C, 32'h002081B3, 64'd9, 64'd7);
        wb_wen = 1'b1; wb_rd = 5'd1; wb_data = 64'h1234;
        tick();
        wb_wen = 1'b0;
        chk("byp_reg1", ex_reg1, 64'h1234);
        chk("byp_reg2", ex_reg2, 7);

        // Load opcode is illegal here
        offer(64'h8000_0010, 32'h0080B203, 64'd1, 64'd2);
        tick();
        chk("ill_opcode", ex_opcode, 7'h03);
        chk("ill_illegal", ex_illegal, 1);
        chk("ill_wen", ex_wen, 0);
        chk("ill_rd", ex_rd, 4);
        if_valid = 1'b0;
        tick();
        chk("drain_empty", ex_valid, 0);

        // Backpressure: A to OUT, B to SKID, C stalled
        ex_ready = 1'b0;
        offer(64'h100, 32'h002081B3, 64'h11, 64'h12);
        tick();
        chk("bp_a_valid", ex_valid, 1);
        chk("bp_one_ready", if_ready, 1);
        offer(64'h104, 32'hFFF00293, 64'h21, 64'h22);
        tick();
        chk("bp_full_ready", if_ready, 0);
        chk("bp_hold_pc1", ex_pc, 64'h100);
        offer(64'h108, 32'h002081B3, 64'h30, 64'h40);
        tick();
        chk("bp_stall_ready", if_ready, 0);
        chk("bp_hold_pc2", ex_pc, 64'h100);
        chk("bp_hold_reg1", ex_reg1, 64'h11);
        chk("bp_hold_reg2", ex_reg2, 64'h12);
        ex_ready = 1'b1;
        tick();
        chk("bp_b_pc", ex_pc, 64'h104);
        chk("bp_b_reg1", ex_reg1, 0);
        chk("bp_b_valid", ex_valid, 1);
        chk("bp_b_ready", if_ready, 1);
        tick();
        if_valid = 1'b0;
        chk("bp_c_pc", ex_pc, 64'h108);
        chk("bp_c_reg1", ex_reg1, 64'h30);
        chk("bp_c_reg2", ex_reg2, 64'h40);
        tick();
        chk("bp_done_valid", ex_valid, 0);

        // Flush while FULL with a concurrent offer
        ex_ready = 1'b0;
        offer(64'h200, 32'h002081B3, 64'h1, 64'h2);
        tick();
        offer(64'h204, 32'h002081B3, 64'h3, 64'h4);
        tick();
        chk("fl_full_ready", if_ready, 0);
        offer(64'h208, 32'h002081B3, 64'h5, 64'h6);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        if_valid = 1'b0;
        chk("fl_valid", ex_valid, 0);
        chk("fl_ready", if_ready, 1);
        ex_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("fl_stays_empty", ex_valid, 0);
        end

        // Asynchronous reset mid-cycle while ONE
        ex_ready = 1'b0;
        offer(64'h300, 32'h002081B3, 64'h77, 64'h88);
        tick();
        if_valid = 1'b0;
        chk("ar_one_valid", ex_valid, 1);
        chk("ar_one_pc", ex_pc, 64'h300);
        #2 reset = 1'b1;
        #1;
        chk("ar_valid", ex_valid, 0);
        chk("ar_pc", ex_pc, 0);
        chk("ar_reg1", ex_reg1, 0);
        chk("ar_reg2", ex_reg2, 0);
        chk("ar_opcode", ex_opcode, 0);
        chk("ar_wen", ex_wen, 0);
        chk("ar_if_ready", if_ready, 0);
        tick();
        reset = 1'b0;
        tick();
        chk("ar_after_ready", if_ready, 1);
        chk("ar_after_valid", ex_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
